// File: rtl/dds_dac_sequencer.sv
// rtl/dds_dac_sequencer.sv - round-robin two-channel DDS-to-DAC SPI frame sequencer
module dds_dac_sequencer #(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 12
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              sample_tick,
   input  logic [DATA_W-1:0] ch0_sample,
   input  logic [DATA_W-1:0] ch1_sample,
   input  logic [1:0]        ch_enable,
   input  logic              clr_status,
   output logic              spi_sck,
   output logic              spi_mosi,
   output logic              spi_cs,
   output logic              busy,
   output logic              frame_done,
   output logic              last_ch,
   output logic              overrun
);

   // Frame is {zero pad, channel bit, sample}; always 16 bits on the wire.
   localparam int         FRAME_PAD = 15 - DATA_W;
   localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t      r_state, w_state;
   logic [7:0]  r_div_cnt, w_div_cnt;
   logic [3:0]  r_bit_cnt, w_bit_cnt;
   logic        r_high, w_high;
   logic [14:0] r_shift, w_shift;
   logic        r_sck, w_sck;
   logic        r_mosi, w_mosi;
   logic        r_cs, w_cs;
   logic        r_frame_done, w_frame_done;
   logic        r_last_ch, w_last_ch;
   logic        r_rr_next, w_rr_next;
   logic        r_overrun, w_overrun;

   logic              w_grant;
   logic [DATA_W-1:0] w_sample;
   logic [15:0]       w_frame;

   // Prefer the pointed-to channel; fall back to the other one when it is disabled.
   assign w_grant  = ch_enable[r_rr_next] ? r_rr_next : ~r_rr_next;
   assign w_sample = w_grant ? ch1_sample : ch0_sample;
   assign w_frame  = {{FRAME_PAD{1'b0}}, w_grant, w_sample};

   // Next-state and next-output computation; every register holds unless a case overrides it.
   always_comb begin
      w_state      = r_state;
      w_div_cnt    = r_div_cnt;
      w_bit_cnt    = r_bit_cnt;
      w_high       = r_high;
      w_shift      = r_shift;
      w_sck        = r_sck;
      w_mosi       = r_mosi;
      w_cs         = r_cs;
      w_frame_done = 1'b0;
      w_last_ch    = r_last_ch;
      w_rr_next    = r_rr_next;
      w_overrun    = r_overrun;

      // Clear first so that an overrunning tick in the same cycle wins.
      if (clr_status) begin
         w_overrun = 1'b0;
      end

      case (r_state)
         ST_IDLE: begin
            if (sample_tick && (ch_enable != 2'b00)) begin
               w_state   = ST_SHIFT;
               w_div_cnt = 8'd0;
               w_bit_cnt = 4'd15;
               w_high    = 1'b0;
               w_shift   = w_frame[14:0];
               w_mosi    = w_frame[15];
               w_sck     = 1'b0;
               w_cs      = 1'b0;
               w_last_ch = w_grant;
               w_rr_next = ~w_grant;
            end
         end
         ST_SHIFT: begin
            if (sample_tick) begin
               w_overrun = 1'b1;
            end
            if (r_div_cnt == DIV_LAST) begin
               w_div_cnt = 8'd0;
               if (!r_high) begin
                  w_high = 1'b1;
                  w_sck  = 1'b1;
               end else if (r_bit_cnt == 4'd0) begin
                  w_state      = ST_GAP;
                  w_high       = 1'b0;
                  w_sck        = 1'b0;
                  w_mosi       = 1'b0;
                  w_cs         = 1'b1;
                  w_frame_done = 1'b1;
               end else begin
                  w_bit_cnt = r_bit_cnt - 4'd1;
                  w_high    = 1'b0;
                  w_sck     = 1'b0;
                  w_mosi    = r_shift[14];
                  w_shift   = {r_shift[13:0], 1'b0};
               end
            end else begin
               w_div_cnt = r_div_cnt + 8'd1;
            end
         end
         ST_GAP: begin
            if (sample_tick) begin
               w_overrun = 1'b1;
            end
            if (r_div_cnt == DIV_LAST) begin
               w_state   = ST_IDLE;
               w_div_cnt = 8'd0;
            end else begin
               w_div_cnt = r_div_cnt + 8'd1;
            end
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any frame and parks the link idle.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_div_cnt    <= 8'd0;
         r_bit_cnt    <= 4'd0;
         r_high       <= 1'b0;
         r_shift      <= 15'd0;
         r_sck        <= 1'b0;
         r_mosi       <= 1'b0;
         r_cs         <= 1'b1;
         r_frame_done <= 1'b0;
         r_last_ch    <= 1'b0;
         r_rr_next    <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_div_cnt    <= w_div_cnt;
         r_bit_cnt    <= w_bit_cnt;
         r_high       <= w_high;
         r_shift      <= w_shift;
         r_sck        <= w_sck;
         r_mosi       <= w_mosi;
         r_cs         <= w_cs;
         r_frame_done <= w_frame_done;
         r_last_ch    <= w_last_ch;
         r_rr_next    <= w_rr_next;
         r_overrun    <= w_overrun;
      end
   end

   assign spi_sck    = r_sck;
   assign spi_mosi   = r_mosi;
   assign spi_cs     = r_cs;
   assign busy       = (r_state != ST_IDLE);
   assign frame_done = r_frame_done;
   assign last_ch    = r_last_ch;
   assign overrun    = r_overrun;

endmodule

// File: doc/dds_dac_sequencer.md
# dds_dac_sequencer

Round-robin SPI sequencer between the DDS sample datapath and the external DAC. On every sample strobe it grants the shared SPI link to one enabled DDS channel, captures that channel's 12-bit amplitude and shifts a 16-bit addressed frame to the DAC. It replaces the fixed single-channel SPI path inside `DDS_generator`. It also reports dropped strobes so the sample-rate/clock-divider configuration can be validated in simulation and on hardware.

## Interface
- `CLK_DIV`, 2: sysclk cycles per SCK half-period; legal range 1..255.
- `DATA_W`, 12: sample width; frame width is fixed at 16.
- `sysclk`  in  1  system clock, 125 MHz
- `reset`  in  1  asynchronous, active-low reset
- `sample_tick`  in  1  one-cycle strobe in the sysclk domain, one per sample period
- `ch0_sample`  in  12  channel 0 amplitude, unsigned
- `ch1_sample`  in  12  channel 1 amplitude, unsigned
- `ch_enable`  in  2  per-channel enable, bit n = channel n
- `clr_status`  in  1  synchronous clear of `overrun`
- `spi_sck`  out  1  SPI clock, mode 0 (idle low, DAC samples on rising edge)
- `spi_mosi`  out  1  serial data, MSB first
- `spi_cs`  out  1  chip select, active low
- `busy`  out  1  frame or CS gap in progress
- `frame_done`  out  1  one-cycle pulse when CS deasserts
- `last_ch`  out  1  channel of the most recently started frame
- `overrun`  out  1  sticky; a tick arrived while busy

## Operation
- Reset values: `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0, `busy`=0, `frame_done`=0, `last_ch`=0, `overrun`=0. The round-robin pointer `rr_next` resets to 0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE, `sample_tick`=1, `ch_enable`≠0:
  - Grant `rr_next` if it is enabled, otherwise grant the other channel.
  - Set `rr_next` = ~grant and `last_ch` = grant.
  - Latch frame = {3'b000, grant, sample[grant]}.
  - Go to SHIFT.
- IDLE, `sample_tick`=1, `ch_enable`=0: ignore the tick. State and pointer are unchanged and `overrun` is not set.
- SHIFT: 16 bits, each lasting one low half followed by one high half, with each half CLK_DIV cycles long.
  - MOSI updates only at the start of a low half.
  - After bit 0's high half completes: go to GAP, `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0, pulse `frame_done`.
- GAP: CS held high for CLK_DIV cycles, then return to IDLE and drop `busy`.
- Samples are captured only at grant. Input changes during a frame do not affect the frame in flight.
- A `sample_tick` in SHIFT or GAP sets `overrun` and is dropped. No queueing, and `rr_next` is unchanged.
- `clr_status` clears `overrun`. If `clr_status` and an overrunning tick occur in the same cycle, set wins.
- `ch_enable` is sampled only at grant. Changing it mid-frame does not affect the current frame.
- Asynchronous reset mid-frame: all outputs return to reset values immediately and the frame is aborted.

## Timing
- Tick sampled at rising edge T (accepted only if `busy`=0 at T).
  - T+1: `spi_cs`=0, `busy`=1, `spi_mosi`=frame[15], `spi_sck`=0.
  - Bit k occupies cycles T+1+2·CLK_DIV·(15−k) .. T+2·CLK_DIV·(16−k).
  - Within bit k, SCK is high for the last CLK_DIV cycles.
  - CS low for exactly 32·CLK_DIV cycles, with 16 rising SCK edges.
  - T+1+32·CLK_DIV: `spi_cs`=1, `frame_done`=1 for one cycle.
  - T+1+33·CLK_DIV: `busy`=0. A tick in this cycle is accepted.
- At CLK_DIV=2, accepted tick spacing is at least 67 cycles. The 125-cycle (1 MHz) sample period fits.
- The output registers are `spi_sck`, `spi_mosi` and `spi_cs`. There is no combinational path from inputs to outputs.

## Test plan
- Reset, CLK_DIV=2, `ch_enable`=2'b01, `ch0_sample`=12'hA5C, single tick at T → CS low T+1..T+64. MOSI is 16'h0A5C MSB first, sampled on 16 rising SCK edges. `frame_done` at T+65, `busy`=0 at T+67, `last_ch`=0.
- `ch_enable`=2'b11, ticks every 125 cycles, ch0=12'h123, ch1=12'h456 → frames alternate 16'h0123, 16'h1456, 16'h0123. `overrun` stays 0.
- `ch_enable`=2'b10 with `rr_next`=0 → channel 1 is granted with frame 16'h1xxx, then `rr_next`=0 again. With `ch_enable`=0, ticks produce no CS activity.
- Second tick at T+30 during a frame → the current frame completes unchanged, `overrun`=1 from T+31, no extra frame is sent. `clr_status` pulse → `overrun`=0. Simultaneous clear and overrunning tick → `overrun`=1.
- `reset` asserted at T+20 mid-frame → `spi_cs`=1, `spi_sck`=0, `busy`=0 without waiting for a clock edge. After release, the next tick grants channel 0.
- CLK_DIV=1, ch0=12'hFFF → CS low for 32 cycles, SCK toggles every cycle, frame 16'h0FFF. Changing `ch0_sample` mid-frame does not alter the shifted bits.
